// File: rtl/mems_dac_spi_tx.sv
// mems_dac_spi_tx
// Sends one DAC command word per start pulse over SPI mode 1, MSB first,
// with cs_n framing. It answers the sequencer's start/busy handshake, and
// data_in comes from a ROM whose synchronous read is valid one cycle after start.
// Frame: IDLE -> LOAD (ROM latency) -> SHIFT (WORD_BITS bits) -> HOLD (cs_n gap).

module mems_dac_spi_tx #(
  parameter int WORD_BITS = 24,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WORD_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 spi_cs_n,
  output logic                 spi_sck,
  output logic                 spi_mosi
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 busy_d, done_d, cs_n_d, sck_d, mosi_d;
  logic                 bit_end;

  // Last divider cycle of the current bit period.
  assign bit_end = (div_q == DIV_LAST);

  // State and output registers. Reset is synchronous and wins in every state.
  // A frame cut short here makes cs_n rise early, so the DAC drops the partial word.
  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      busy       <= busy_d;
      frame_done <= done_d;
      spi_cs_n   <= cs_n_d;
      spi_sck    <= sck_d;
      spi_mosi   <= mosi_d;
    end
  end

  // Next-state logic. start is looked at only in IDLE, so requests made while busy are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_end && (bit_q == BIT_LAST)) state_d = HOLD;
      HOLD:    if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next datapath and pin values. These are registered above, so the pins follow state_d in step.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == HOLD) && (state_d == IDLE);
    cs_n_d  = (state_d != SHIFT);
    sck_d   = 1'b0;
    mosi_d  = 1'b0;

    case (state_q)
      LOAD: shreg_d = data_in;
      SHIFT: begin
        div_d = bit_end ? '0 : div_q + DIV_W'(1);
        if (bit_end) begin
          bit_d   = bit_q + CNT_W'(1);
          shreg_d = shreg_q << 1;
        end
      end
      HOLD:    gap_d = gap_q + GAP_W'(1);
      default: ;
    endcase

    // Each state starts with its counters at zero.
    if (state_d != state_q) begin
      bit_d = '0;
      div_d = '0;
      gap_d = '0;
    end

    // sck is high for the first half of each bit period. mosi changes on the rising edge.
    if (state_d == SHIFT) begin
      sck_d  = (div_d < DIV_HALF);
      mosi_d = shreg_d[WORD_BITS-1];
    end
  end

endmodule
